// File: rtl/pipe_stage_skid_reg.sv
// One pipeline stage: opaque data bundle plus control bundle behind a valid/ready
// handshake, with an optional one-entry skid buffer, synchronous flush and perf counters.
module pipe_stage_skid_reg #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 24,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Flush,
   input  logic              InValid,
   output logic              InReady,
   input  logic [DATA_W-1:0] InData,
   input  logic [CTRL_W-1:0] InCtrl,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [DATA_W-1:0] OutData,
   output logic [CTRL_W-1:0] OutCtrl,
   output logic [CNT_W-1:0]  BubbleCount,
   output logic [CNT_W-1:0]  StallCount
);

   // Handshake: a beat moves on an edge exactly when valid and ready are both high in the
   // cycle before it; valid never waits on ready, and a held beat stays stable until taken.
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic              mValid;
   logic [DATA_W-1:0] mData;
   logic [CTRL_W-1:0] mCtrl;
   logic              inFire;
   logic              outFire;

   assign inFire  = InValid & InReady;
   assign outFire = mValid & OutReady;

   generate
      if (SKID != 0) begin : g_skid
         logic              sValid;
         logic [DATA_W-1:0] sData;
         logic [CTRL_W-1:0] sCtrl;

         always_ff @(posedge Clk) begin
            if (Rst) begin
               mValid <= 1'b0;
               mData  <= '0;
               mCtrl  <= '0;
               sValid <= 1'b0;
               sData  <= '0;
               sCtrl  <= '0;
            end else if (Flush) begin
               mValid <= 1'b0;
               mCtrl  <= '0;
               sValid <= 1'b0;
               sCtrl  <= '0;
            end else if (!mValid) begin
               // S is always empty while M is empty, so InReady is high here.
               if (inFire) begin
                  mValid <= 1'b1;
                  mData  <= InData;
                  mCtrl  <= InCtrl;
               end
            end else if (outFire) begin
               if (sValid) begin
                  mData  <= sData;
                  mCtrl  <= sCtrl;
                  sValid <= 1'b0;
               end else if (inFire) begin
                  mData <= InData;
                  mCtrl <= InCtrl;
               end else begin
                  mValid <= 1'b0;
                  mCtrl  <= '0;
               end
            end else if (inFire) begin
               sValid <= 1'b1;
               sData  <= InData;
               sCtrl  <= InCtrl;
            end
         end

         // Registered ready: upstream timing never sees the downstream OutReady path.
         assign InReady = ~sValid;
      end else begin : g_noskid
         always_ff @(posedge Clk) begin
            if (Rst) begin
               mValid <= 1'b0;
               mData  <= '0;
               mCtrl  <= '0;
            end else if (Flush) begin
               mValid <= 1'b0;
               mCtrl  <= '0;
            end else if (inFire) begin
               mValid <= 1'b1;
               mData  <= InData;
               mCtrl  <= InCtrl;
            end else if (outFire) begin
               mValid <= 1'b0;
               mCtrl  <= '0;
            end
         end

         assign InReady = ~mValid | OutReady;
      end
   endgenerate

   always_ff @(posedge Clk) begin
      if (Rst) begin
         BubbleCount <= '0;
         StallCount  <= '0;
      end else begin
         if (!mValid && (BubbleCount != '1)) BubbleCount <= BubbleCount + CNT_ONE;
         if (mValid && !OutReady && (StallCount != '1)) StallCount <= StallCount + CNT_ONE;
      end
   end

   assign OutValid = mValid;
   assign OutData  = mData;
   assign OutCtrl  = mCtrl;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: a skid build and a no-skid build (4-bit counters) share
// stimulus; queue models of each stage's held beats are compared every cycle.
module tb_pipe_stage_skid_reg;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [127:0] in_data;
  logic [23:0]  in_ctrl;
  logic         out_ready;

  logic         a_in_ready, a_out_valid;
  logic [127:0] a_out_data;
  logic [23:0]  a_out_ctrl;
  logic [15:0]  a_bubble, a_stall;

  logic         b_in_ready, b_out_valid;
  logic [15:0]  b_out_data;
  logic [7:0]   b_out_ctrl;
  logic [3:0]   b_bubble, b_stall;

  pipe_stage_skid_reg #(.DATA_W(128), .CTRL_W(24), .SKID(1), .CNT_W(16)) dut_a (
    .Clk(clk), .Rst(rst), .Flush(flush),
    .InValid(in_valid), .InReady(a_in_ready), .InData(in_data), .InCtrl(in_ctrl),
    .OutValid(a_out_valid), .OutReady(out_ready), .OutData(a_out_data), .OutCtrl(a_out_ctrl),
    .BubbleCount(a_bubble), .StallCount(a_stall)
  );

  pipe_stage_skid_reg #(.DATA_W(16), .CTRL_W(8), .SKID(0), .CNT_W(4)) dut_b (
    .Clk(clk), .Rst(rst), .Flush(flush),
    .InValid(in_valid), .InReady(b_in_ready), .InData(in_data[15:0]), .InCtrl(in_ctrl[7:0]),
    .OutValid(b_out_valid), .OutReady(out_ready), .OutData(b_out_data), .OutCtrl(b_out_ctrl),
    .BubbleCount(b_bubble), .StallCount(b_stall)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [151:0] exp_qa[$];  // {ctrl, data} beats held by the skid stage, oldest first
  logic [23:0]  exp_qb[$];  // same for the no-skid stage
  int           bub_a, stall_a, bub_b, stall_b;
  bit           armed;
  int           checks;
  int           errors;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  always @(posedge clk) begin
    bit fire_out_a, fire_in_a, fire_out_b, fire_in_b;
    fire_out_a = (exp_qa.size() > 0) && out_ready;
    fire_in_a  = in_valid && (exp_qa.size() < 2);
    fire_out_b = (exp_qb.size() > 0) && out_ready;
    fire_in_b  = in_valid && ((exp_qb.size() == 0) || out_ready);
    if (rst) begin
      exp_qa.delete();
      exp_qb.delete();
      bub_a = 0; stall_a = 0; bub_b = 0; stall_b = 0;
      armed = 1'b1;
    end else if (armed) begin
      if (exp_qa.size() == 0 && bub_a < 65535) bub_a++;
      if (exp_qa.size() > 0 && !out_ready && stall_a < 65535) stall_a++;
      if (exp_qb.size() == 0 && bub_b < 15) bub_b++;
      if (exp_qb.size() > 0 && !out_ready && stall_b < 15) stall_b++;
      if (flush) begin
        exp_qa.delete();
        exp_qb.delete();
      end else begin
        if (fire_out_a) void'(exp_qa.pop_front());
        if (fire_in_a) exp_qa.push_back({in_ctrl, in_data});
        if (fire_out_b) void'(exp_qb.pop_front());
        if (fire_in_b) exp_qb.push_back({in_ctrl[7:0], in_data[15:0]});
      end
    end
  end

  // Monitor: compare what each stage presents against the head of its expected queue.
  always @(negedge clk) begin
    if (armed) begin
      check("a_in_ready", a_in_ready, exp_qa.size() < 2);
      check("a_out_valid", a_out_valid, exp_qa.size() > 0);
      check("a_out_ctrl", a_out_ctrl, (exp_qa.size() > 0) ? exp_qa[0][151:128] : 24'h0);
      if (exp_qa.size() > 0) check("a_out_data", a_out_data, exp_qa[0][127:0]);
      check("a_bubble", a_bubble, bub_a);
      check("a_stall", a_stall, stall_a);
      check("b_in_ready", b_in_ready, (exp_qb.size() == 0) || out_ready);
      check("b_out_valid", b_out_valid, exp_qb.size() > 0);
      check("b_out_ctrl", b_out_ctrl, (exp_qb.size() > 0) ? exp_qb[0][23:16] : 8'h0);
      if (exp_qb.size() > 0) check("b_out_data", b_out_data, exp_qb[0][15:0]);
      check("b_bubble", b_bubble, bub_b);
      check("b_stall", b_stall, stall_b);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [23:0] c, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    out_ready = ordy;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; errors = 0; armed = 1'b0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 128'hAB; in_ctrl = 24'h0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_ctrl", a_out_ctrl, 24'h0);
    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_bubble", a_bubble, 16'd0);
    check("rst_stall", a_stall, 16'd0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("rst_bubble_one", a_bubble, 16'd1);

    for (int c = 1; c <= 5; c++) drive(1'b0, 1'b1, c[23:0], 1'b1);
    repeat (2) drive(1'b0, 1'b0, 24'h0, 1'b1);
    check("stream_stall_zero", a_stall, 16'd0);

    drive(1'b0, 1'b1, 24'h11, 1'b0);
    drive(1'b0, 1'b1, 24'h22, 1'b0);
    check("bp_in_ready_low", a_in_ready, 1'b0);
    check("bp_head", a_out_ctrl, 24'h11);
    drive(1'b0, 1'b1, 24'h33, 1'b0);
    repeat (3) drive(1'b0, 1'b1, 24'h33, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 24'h0, 1'b1);

    drive(1'b0, 1'b1, 24'h11, 1'b0);
    drive(1'b0, 1'b1, 24'h22, 1'b0);
    drive(1'b1, 1'b1, 24'h33, 1'b0);
    check("flush_out_valid", a_out_valid, 1'b0);
    check("flush_out_ctrl", a_out_ctrl, 24'h0);
    check("flush_in_ready", a_in_ready, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 24'h0, 1'b1);

    drive(1'b0, 1'b1, 24'h44, 1'b0);
    in_valid = 1'b1; in_ctrl = 24'h55; in_data = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    #1;
    check("noskid_ready_low", b_in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    check("noskid_ready_comb", b_in_ready, 1'b1);
    step();
    check("noskid_replace_valid", b_out_valid, 1'b1);
    check("noskid_replace_ctrl", b_out_ctrl, 8'h55);

    rst = 1'b1;
    drive(1'b0, 1'b1, 24'h66, 1'b0);
    rst = 1'b0;
    repeat (20) drive(1'b0, 1'b0, 24'h0, 1'b1);
    check("sat_bubble_b", b_bubble, 4'd15);
    check("bubble_a_20", a_bubble, 16'd20);

    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, 24'($urandom),
            $urandom_range(0, 9) < 6);
    end
    rst = 1'b0;
    repeat (4) drive(1'b0, 1'b0, 24'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
